// File: rtl/res_st_ooo_pkg.sv
// Shared types for the out-of-order reservation station: default ROB-tag and
// register-file data widths, the "operand ready" tag value and the entry layout.
package res_st_ooo_pkg;

    localparam int ROB_ADDR_W    = 5;
    localparam int PHY_RF_DATA_W = 32;
    localparam int RES_ST_OP_W   = 8;

    typedef logic [ROB_ADDR_W-1:0]    rob_addr_t;
    typedef logic [PHY_RF_DATA_W-1:0] phy_rf_data_t;

    // Tag 0 is never handed out by the ROB, so it doubles as "value present".
    localparam rob_addr_t TAG_READY = '0;

    typedef struct packed {
        logic                   busy;
        logic [RES_ST_OP_W-1:0] op;
        rob_addr_t              dest;
        rob_addr_t              qj;
        phy_rf_data_t           vj;
        rob_addr_t              qk;
        phy_rf_data_t           vk;
    } res_st_ooo_entry_t;

endpackage

// File: rtl/res_st_ooo_if.sv
// Dispatch, CDB and issue signals of the reservation station; the station
// itself connects through the slave modport, its environment through master.
interface res_st_ooo_if #(
    parameter int RES_ST_DEPTH = 16,
    parameter int NUM_CDB      = 2,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 5,
    parameter int OP_W         = 8
);
    logic                              flush_in;
    logic                              alloc_valid;
    logic                              alloc_ready;
    logic [OP_W-1:0]                   alloc_op;
    logic [TAG_W-1:0]                  alloc_dest;
    logic [TAG_W-1:0]                  alloc_qj;
    logic [TAG_W-1:0]                  alloc_qk;
    logic [DATA_W-1:0]                 alloc_vj;
    logic [DATA_W-1:0]                 alloc_vk;
    logic [NUM_CDB-1:0]                cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]          cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]         cdb_value;
    logic                              iss_valid;
    logic                              iss_ready;
    logic [OP_W-1:0]                   iss_op;
    logic [TAG_W-1:0]                  iss_dest;
    logic [DATA_W-1:0]                 iss_vj;
    logic [DATA_W-1:0]                 iss_vk;
    logic [$clog2(RES_ST_DEPTH)-1:0]   iss_idx;
    logic [$clog2(RES_ST_DEPTH+1)-1:0] occupancy;
    logic                              full;
    logic                              empty;

    modport slave (
        input  flush_in, alloc_valid, alloc_op, alloc_dest, alloc_qj, alloc_qk,
               alloc_vj, alloc_vk, cdb_valid, cdb_tag, cdb_value, iss_ready,
        output alloc_ready, iss_valid, iss_op, iss_dest, iss_vj, iss_vk,
               iss_idx, occupancy, full, empty
    );

    modport master (
        output flush_in, alloc_valid, alloc_op, alloc_dest, alloc_qj, alloc_qk,
               alloc_vj, alloc_vk, cdb_valid, cdb_tag, cdb_value, iss_ready,
        input  alloc_ready, iss_valid, iss_op, iss_dest, iss_vj, iss_vk,
               iss_idx, occupancy, full, empty
    );

endinterface

// File: rtl/res_st_age_sel.sv
// Age matrix plus oldest-ready selection: older_q[i][j]=1 means entry j was
// allocated before entry i. Exactly one grant whenever any entry is ready.
module res_st_age_sel #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic [DEPTH-1:0]         busy,
    input  logic [DEPTH-1:0]         ready,
    output logic [DEPTH-1:0]         grant,
    output logic [$clog2(DEPTH)-1:0] grant_idx,
    output logic                     any_ready
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] older_q [DEPTH];

    // A new entry is younger than every busy entry and older than nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else if (alloc_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_idx == IDX_W'(i)) older_q[i] <= busy & ~(DEPTH'(1) << i);
                else                        older_q[i][alloc_idx] <= 1'b0;
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i] && !(|(older_q[i] & ready));
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

    assign any_ready = |ready;

endmodule

// File: rtl/res_st_ooo.sv
// Out-of-order reservation station: self-allocating entries, multi-CDB wakeup
// with allocate-time bypass, oldest-ready issue and a full squash.
module res_st_ooo
    import res_st_ooo_pkg::*;
#(
    parameter int RES_ST_DEPTH = 16,
    parameter int NUM_CDB      = 2,
    parameter int DATA_W       = $bits(phy_rf_data_t),
    parameter int TAG_W        = $bits(rob_addr_t),
    parameter int OP_W         = 8
) (
    input logic         clk,
    input logic         rst,
    res_st_ooo_if.slave bus
);

    localparam int IDX_W = $clog2(RES_ST_DEPTH);
    localparam int CNT_W = $clog2(RES_ST_DEPTH + 1);
    localparam logic [TAG_W-1:0] TAG_RDY = TAG_W'(TAG_READY);

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vk;
    } entry_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] value;
    } snoop_t;

    entry_t                  ent_q [RES_ST_DEPTH];
    snoop_t                  wake_j [RES_ST_DEPTH];
    snoop_t                  wake_k [RES_ST_DEPTH];
    snoop_t                  byp_j, byp_k;
    entry_t                  alloc_ent;
    logic [RES_ST_DEPTH-1:0] busy, ready, grant;
    logic [IDX_W-1:0]        free_idx, grant_idx;
    logic [CNT_W-1:0]        occ;
    logic                    any_ready, full_w, alloc_fire, iss_fire;

    // Lowest CDB port wins; a pending tag of 0 can never match, which also
    // makes tag-0 broadcasts harmless.
    function automatic snoop_t cdb_snoop(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        snoop_t r;
        r = '0;
        if (tag != TAG_RDY) begin
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (vld[p] && tags[p*TAG_W +: TAG_W] == tag) begin
                    r.hit   = 1'b1;
                    r.value = vals[p*DATA_W +: DATA_W];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            busy[i]   = ent_q[i].busy;
            ready[i]  = ent_q[i].busy && ent_q[i].qj == TAG_RDY && ent_q[i].qk == TAG_RDY;
            wake_j[i] = cdb_snoop(ent_q[i].qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            wake_k[i] = cdb_snoop(ent_q[i].qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = RES_ST_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < RES_ST_DEPTH; i++) occ = occ + CNT_W'(busy[i]);
    end

    always_comb begin
        byp_j          = cdb_snoop(bus.alloc_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        byp_k          = cdb_snoop(bus.alloc_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        alloc_ent      = '0;
        alloc_ent.busy = 1'b1;
        alloc_ent.op   = bus.alloc_op;
        alloc_ent.dest = bus.alloc_dest;
        alloc_ent.qj   = byp_j.hit ? TAG_RDY : bus.alloc_qj;
        alloc_ent.vj   = byp_j.hit ? byp_j.value : bus.alloc_vj;
        alloc_ent.qk   = byp_k.hit ? TAG_RDY : bus.alloc_qk;
        alloc_ent.vk   = byp_k.hit ? byp_k.value : bus.alloc_vk;
    end

    // alloc_ready comes from registered busy bits only, so a slot freed by
    // this cycle's issue is not reused until the next cycle.
    assign full_w     = &busy;
    assign alloc_fire = bus.alloc_valid && !full_w && !bus.flush_in;
    assign iss_fire   = any_ready && bus.iss_ready && !bus.flush_in;

    res_st_age_sel #(.DEPTH(RES_ST_DEPTH)) u_age_sel (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (alloc_fire),
        .alloc_idx (free_idx),
        .busy      (busy),
        .ready     (ready),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_ready (any_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RES_ST_DEPTH; i++) ent_q[i] <= '0;
        end else if (bus.flush_in) begin
            for (int i = 0; i < RES_ST_DEPTH; i++) ent_q[i].busy <= 1'b0;
        end else begin
            for (int i = 0; i < RES_ST_DEPTH; i++) begin
                if (alloc_fire && free_idx == IDX_W'(i)) begin
                    ent_q[i] <= alloc_ent;
                end else if (ent_q[i].busy) begin
                    if (iss_fire && grant[i]) ent_q[i].busy <= 1'b0;
                    if (wake_j[i].hit) begin
                        ent_q[i].qj <= TAG_RDY;
                        ent_q[i].vj <= wake_j[i].value;
                    end
                    if (wake_k[i].hit) begin
                        ent_q[i].qk <= TAG_RDY;
                        ent_q[i].vk <= wake_k[i].value;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.iss_op   = '0;
        bus.iss_dest = '0;
        bus.iss_vj   = '0;
        bus.iss_vk   = '0;
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            if (grant[i]) begin
                bus.iss_op   = ent_q[i].op;
                bus.iss_dest = ent_q[i].dest;
                bus.iss_vj   = ent_q[i].vj;
                bus.iss_vk   = ent_q[i].vk;
            end
        end
    end

    assign bus.iss_valid   = any_ready;
    assign bus.iss_idx     = grant_idx;
    assign bus.alloc_ready = !full_w;
    assign bus.full        = full_w;
    assign bus.empty       = ~|busy;
    assign bus.occupancy   = occ;

endmodule

// File: tb/tb_res_st_ooo.sv
// Directed bench for res_st_ooo: issue ordering, wakeup/bypass, full/flush and
// asynchronous reset, with hand-computed expected values.
module tb_res_st_ooo;

    localparam int DEPTH = 16;
    localparam int NCDB  = 2;
    localparam int DW    = 32;
    localparam int TW    = 5;
    localparam int OW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    res_st_ooo_if #(.RES_ST_DEPTH(DEPTH), .NUM_CDB(NCDB), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) bus ();

    res_st_ooo #(.RES_ST_DEPTH(DEPTH), .NUM_CDB(NCDB), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.flush_in    = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.cdb_valid   = '0;
    endtask

    task automatic offer(input logic [7:0] op, input logic [4:0] dest, input logic [4:0] qj,
                         input logic [31:0] vj, input logic [4:0] qk, input logic [31:0] vk);
        bus.alloc_valid = 1'b1;
        bus.alloc_op    = op;
        bus.alloc_dest  = dest;
        bus.alloc_qj    = qj;
        bus.alloc_vj    = vj;
        bus.alloc_qk    = qk;
        bus.alloc_vk    = vk;
    endtask

    task automatic cdb(input int p, input logic [4:0] tag, input logic [31:0] val);
        bus.cdb_valid[p]          = 1'b1;
        bus.cdb_tag[p*TW +: TW]   = tag;
        bus.cdb_value[p*DW +: DW] = val;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        bus.iss_ready  = 1'b0;
        bus.alloc_op   = '0;
        bus.alloc_dest = '0;
        bus.alloc_qj   = '0;
        bus.alloc_qk   = '0;
        bus.alloc_vj   = '0;
        bus.alloc_vk   = '0;
        bus.cdb_tag    = '0;
        bus.cdb_value  = '0;
        #12;
        chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        chk("rst_empty",       64'(bus.empty),       64'd1);
        chk("rst_full",        64'(bus.full),        64'd0);
        chk("rst_iss_valid",   64'(bus.iss_valid),   64'd0);
        chk("rst_occ",         64'(bus.occupancy),   64'd0);
        chk("rst_iss_vj",      64'(bus.iss_vj),      64'd0);
        rst = 1'b1;

        // in-order issue of three ready entries
        offer(8'h10, 5'd1, 5'd0, 32'h100, 5'd0, 32'h0); tick();
        offer(8'h11, 5'd2, 5'd0, 32'h101, 5'd0, 32'h0); tick();
        offer(8'h12, 5'd3, 5'd0, 32'h102, 5'd0, 32'h0); tick();
        idle();
        chk("s1_occ3",   64'(bus.occupancy), 64'd3);
        chk("s1_idx0",   64'(bus.iss_idx),   64'd0);
        tick();
        chk("s1_hold_op", 64'(bus.iss_op),   64'h10);
        bus.iss_ready = 1'b1;
        tick();
        chk("s1_idx1",   64'(bus.iss_idx),   64'd1);
        chk("s1_op1",    64'(bus.iss_op),    64'h11);
        chk("s1_occ2",   64'(bus.occupancy), 64'd2);
        tick();
        chk("s1_idx2",   64'(bus.iss_idx),   64'd2);
        chk("s1_vj2",    64'(bus.iss_vj),    64'h102);
        tick();
        chk("s1_empty",  64'(bus.empty),     64'd1);
        chk("s1_ivld",   64'(bus.iss_valid), 64'd0);
        chk("s1_occ0",   64'(bus.occupancy), 64'd0);
        bus.iss_ready = 1'b0;

        // wakeup lets younger ready entry go first; port 0 wins on double match
        offer(8'h20, 5'd4, 5'd5, 32'h0, 5'd0, 32'h7); tick();
        offer(8'h21, 5'd6, 5'd0, 32'hA, 5'd0, 32'hB); tick();
        idle();
        chk("s2_idxB", 64'(bus.iss_idx), 64'd1);
        chk("s2_opB",  64'(bus.iss_op),  64'h21);
        cdb(0, 5'd5, 32'hDEAD);
        cdb(1, 5'd5, 32'hBEEF);
        bus.iss_ready = 1'b1;
        tick();
        idle();
        chk("s2_idxA", 64'(bus.iss_idx),   64'd0);
        chk("s2_vjA",  64'(bus.iss_vj),    64'hDEAD);
        chk("s2_opA",  64'(bus.iss_op),    64'h20);
        chk("s2_vkA",  64'(bus.iss_vk),    64'h7);
        chk("s2_occ1", 64'(bus.occupancy), 64'd1);
        tick();
        chk("s2_empty", 64'(bus.empty), 64'd1);
        bus.iss_ready = 1'b0;

        // allocate-time bypass on both operands, then a tag-0 broadcast
        offer(8'h30, 5'd8, 5'd7, 32'h0, 5'd9, 32'h0);
        cdb(0, 5'd7, 32'h11);
        cdb(1, 5'd9, 32'h22);
        chk("s3_pre_ivld", 64'(bus.iss_valid), 64'd0);
        tick();
        idle();
        cdb(1, 5'd0, 32'h99);
        tick();
        idle();
        chk("s3_ivld", 64'(bus.iss_valid), 64'd1);
        chk("s3_vj",   64'(bus.iss_vj),    64'h11);
        chk("s3_vk",   64'(bus.iss_vk),    64'h22);
        chk("s3_dest", 64'(bus.iss_dest),  64'd8);
        bus.iss_ready = 1'b1;
        tick();
        chk("s3_empty", 64'(bus.empty), 64'd1);
        bus.iss_ready = 1'b0;

        // fill, drop extra alloc, free one slot and refill it
        for (int i = 0; i < DEPTH; i++) begin
            offer(8'(8'h40 + i), 5'(i + 1), 5'd0, 32'(i), 5'd0, 32'h0);
            tick();
        end
        idle();
        chk("s4_full",   64'(bus.full),        64'd1);
        chk("s4_aready", 64'(bus.alloc_ready), 64'd0);
        chk("s4_occ16",  64'(bus.occupancy),   64'd16);
        offer(8'hEE, 5'd30, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        chk("s4_drop_occ", 64'(bus.occupancy), 64'd16);
        offer(8'hEF, 5'd31, 5'd0, 32'h0, 5'd0, 32'h0);
        bus.iss_ready = 1'b1;
        tick();
        bus.iss_ready = 1'b0;
        chk("s4_occ15",   64'(bus.occupancy),   64'd15);
        chk("s4_aready1", 64'(bus.alloc_ready), 64'd1);
        tick();
        idle();
        chk("s4_refill_occ", 64'(bus.occupancy), 64'd16);
        bus.iss_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk("s4_drain_idx", 64'(bus.iss_idx), (k < DEPTH - 1) ? 64'(k + 1) : 64'd0);
            chk("s4_drain_op",  64'(bus.iss_op),  (k < DEPTH - 1) ? 64'(8'h40 + k + 1) : 64'hEF);
            tick();
        end
        chk("s4_empty", 64'(bus.empty), 64'd1);
        bus.iss_ready = 1'b0;

        // age beats index after reallocating slot 0
        for (int i = 0; i < 4; i++) begin
            offer(8'(8'h50 + i), 5'(i + 1), 5'd0, 32'h0, 5'd0, 32'h0);
            tick();
        end
        idle();
        bus.iss_ready = 1'b1;
        chk("s5_first0", 64'(bus.iss_idx), 64'd0);
        tick();
        bus.iss_ready = 1'b0;
        offer(8'h5A, 5'd20, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        idle();
        chk("s5_occ4", 64'(bus.occupancy), 64'd4);
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("s5_order_idx", 64'(bus.iss_idx), (k < 3) ? 64'(k + 1) : 64'd0);
            chk("s5_order_op",  64'(bus.iss_op),  (k < 3) ? 64'(8'h50 + k + 1) : 64'h5A);
            tick();
        end
        chk("s5_empty", 64'(bus.empty), 64'd1);
        bus.iss_ready = 1'b0;

        // flush overrides a concurrent allocate and issue
        for (int i = 0; i < 5; i++) begin
            offer(8'(8'h60 + i), 5'(i + 1), 5'd0, 32'h0, 5'd0, 32'h0);
            tick();
        end
        idle();
        chk("s6_occ5", 64'(bus.occupancy), 64'd5);
        offer(8'h66, 5'd10, 5'd0, 32'h0, 5'd0, 32'h0);
        bus.flush_in  = 1'b1;
        bus.iss_ready = 1'b1;
        tick();
        idle();
        bus.iss_ready = 1'b0;
        chk("s6_occ0",  64'(bus.occupancy), 64'd0);
        chk("s6_empty", 64'(bus.empty),     64'd1);
        chk("s6_ivld",  64'(bus.iss_valid), 64'd0);

        // asynchronous reset between clock edges
        offer(8'h70, 5'd1, 5'd0, 32'h1234, 5'd0, 32'h0); tick();
        offer(8'h71, 5'd2, 5'd0, 32'h0, 5'd0, 32'h0); tick();
        idle();
        chk("s7_occ2", 64'(bus.occupancy), 64'd2);
        #1;
        rst = 1'b0;
        #1;
        chk("s7_rst_occ",    64'(bus.occupancy),   64'd0);
        chk("s7_rst_ivld",   64'(bus.iss_valid),   64'd0);
        chk("s7_rst_empty",  64'(bus.empty),       64'd1);
        chk("s7_rst_op",     64'(bus.iss_op),      64'd0);
        chk("s7_rst_vj",     64'(bus.iss_vj),      64'd0);
        chk("s7_rst_aready", 64'(bus.alloc_ready), 64'd1);
        rst = 1'b1;
        tick();
        chk("s7_post_empty", 64'(bus.empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
